baud_nco_gen: RTL and testbench

Parametrised, runtime-programmable baud-rate enable generator; next generation of the fixed divide-by-N enable dividers that feed the RS-232 TX/RX engines. A phase accumulator (NCO) produces an oversampled RX enable at a fractional ratio of `clk`. A derived 1x TX enable is aligned to every OVS-th RX enable. Sits in the clock domain of the DCM output that drives it, gated by that DCM's lock signal.

---
 rtl/baud_nco_gen.sv | 149 ++++++++++++++
 tb/tb_baud_nco_gen.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/baud_nco_gen.sv
// baud_nco_gen: runtime-programmable NCO baud enable generator (oversampled RX enable, 1x TX enable).
// Optional lock qualification filter is compiled in by defining BAUD_NCO_LOCK_FILTER_EN.
module baud_nco_gen #(
   parameter int unsigned ACC_W       = 24,
   parameter int unsigned OVS         = 8,
   parameter int unsigned LOCK_CYCLES = 16,
   parameter int unsigned DEFAULT_INC = 1863709
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    locked,
   input  logic [ACC_W-1:0]        inc_data,
   input  logic                    inc_load,
   output logic                    inc_busy,
   output logic                    running,
   output logic                    rx_en,
   output logic                    tx_en,
   output logic [$clog2(OVS)-1:0]  sub_phase
);

   localparam int unsigned      SP_W     = $clog2(OVS);
   localparam logic [SP_W-1:0]  OVS_LAST = SP_W'(OVS - 1);
   localparam logic [ACC_W-1:0] INC_RST  = ACC_W'(DEFAULT_INC);

   logic [ACC_W-1:0] acc_q, acc_d;
   logic [ACC_W-1:0] inc_q, inc_d;
   logic [ACC_W-1:0] pend_q, pend_d;
   logic             busy_q, busy_d;
   logic [SP_W-1:0]  ovs_q, ovs_d;
   logic             rx_q, rx_d;
   logic             tx_q, tx_d;
   logic             run_q, run_d;

   logic [ACC_W:0]   sum_s;
   logic             carry_s;
   logic             bit_end_s;
   logic             apply_s;
   logic             run_next_s;

`ifdef BAUD_NCO_LOCK_FILTER_EN
   localparam int unsigned     LC_W     = $clog2(LOCK_CYCLES + 1);
   localparam logic [LC_W-1:0] LOCK_TGT = LC_W'(LOCK_CYCLES);

   logic [LC_W-1:0] lock_cnt_q, lock_cnt_d;

   // Lock qualification: count consecutive locked cycles, saturating at the target.
   always_comb begin
      lock_cnt_d = lock_cnt_q;
      if (!locked) begin
         lock_cnt_d = {LC_W{1'b0}};
      end else if (lock_cnt_q != LOCK_TGT) begin
         lock_cnt_d = lock_cnt_q + LC_W'(1);
      end else begin
         lock_cnt_d = lock_cnt_q;
      end
   end

   assign run_next_s = locked & (lock_cnt_d == LOCK_TGT);

   // Lock qualification counter register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lock_cnt_q <= {LC_W{1'b0}};
      end else begin
         lock_cnt_q <= lock_cnt_d;
      end
   end
`else
   assign run_next_s = locked;
`endif

   // Phase accumulator, oversample counter and increment load/apply next-state logic.
   always_comb begin
      sum_s     = {1'b0, acc_q} + {1'b0, inc_q};
      carry_s   = run_q & sum_s[ACC_W];
      bit_end_s = carry_s & (ovs_q == OVS_LAST);
      // A pending increment lands on a bit boundary, or at once when nothing is counting.
      apply_s   = busy_q & (bit_end_s | ~run_q | (inc_q == {ACC_W{1'b0}}));

      acc_d  = acc_q;
      ovs_d  = ovs_q;
      rx_d   = 1'b0;
      tx_d   = 1'b0;
      inc_d  = inc_q;
      pend_d = pend_q;
      busy_d = busy_q;
      run_d  = run_next_s;

      if (!locked) begin
         acc_d = {ACC_W{1'b0}};
         ovs_d = {SP_W{1'b0}};
      end else if (run_q) begin
         acc_d = sum_s[ACC_W-1:0];
         rx_d  = carry_s;
         tx_d  = bit_end_s;
         if (bit_end_s) begin
            ovs_d = {SP_W{1'b0}};
         end else if (carry_s) begin
            ovs_d = ovs_q + SP_W'(1);
         end else begin
            ovs_d = ovs_q;
         end
      end else begin
         acc_d = acc_q;
         ovs_d = ovs_q;
      end

      if (apply_s) begin
         inc_d  = pend_q;
         busy_d = 1'b0;
      end else if (inc_load && !busy_q) begin
         pend_d = inc_data;
         busy_d = 1'b1;
      end else begin
         pend_d = pend_q;
         busy_d = busy_q;
      end
   end

   // State and registered output flops.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         acc_q  <= {ACC_W{1'b0}};
         inc_q  <= INC_RST;
         pend_q <= {ACC_W{1'b0}};
         busy_q <= 1'b0;
         ovs_q  <= {SP_W{1'b0}};
         rx_q   <= 1'b0;
         tx_q   <= 1'b0;
         run_q  <= 1'b0;
      end else begin
         acc_q  <= acc_d;
         inc_q  <= inc_d;
         pend_q <= pend_d;
         busy_q <= busy_d;
         ovs_q  <= ovs_d;
         rx_q   <= rx_d;
         tx_q   <= tx_d;
         run_q  <= run_d;
      end
   end

   assign inc_busy  = busy_q;
   assign running   = run_q;
   assign rx_en     = rx_q;
   assign tx_en     = tx_q;
   assign sub_phase = ovs_q;

endmodule

// File: tb/tb_baud_nco_gen.sv
// Directed self-checking bench for baud_nco_gen (ACC_W=8, OVS=4, LOCK_CYCLES=4, DEFAULT_INC=64).
module tb_baud_nco_gen;

   localparam int ACC_W       = 8;
   localparam int OVS         = 4;
   localparam int LOCK_CYCLES = 4;
   localparam int DEFAULT_INC = 64;
`ifdef BAUD_NCO_LOCK_FILTER_EN
   localparam int LOCK_LAT = LOCK_CYCLES;
`else
   localparam int LOCK_LAT = 1;
`endif

   logic             clk = 1'b0;
   logic             reset;
   logic             locked;
   logic [ACC_W-1:0] inc_data;
   logic             inc_load;
   logic             inc_busy;
   logic             running;
   logic             rx_en;
   logic             tx_en;
   logic [1:0]       sub_phase;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   baud_nco_gen #(
      .ACC_W(ACC_W), .OVS(OVS), .LOCK_CYCLES(LOCK_CYCLES), .DEFAULT_INC(DEFAULT_INC)
   ) dut (
      .clk(clk), .reset(reset), .locked(locked), .inc_data(inc_data), .inc_load(inc_load),
      .inc_busy(inc_busy), .running(running), .rx_en(rx_en), .tx_en(tx_en), .sub_phase(sub_phase)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // running must rise exactly on the LOCK_LAT-th locked edge, with no enables meanwhile
   task automatic qualify(input string tag);
      for (int i = 1; i <= LOCK_LAT; i++) begin
         tick();
         check({tag, "_running"}, 32'(running), (i == LOCK_LAT) ? 32'd1 : 32'd0);
         check({tag, "_rx_quiet"}, 32'(rx_en), 32'd0);
      end
   endtask

   // wait for the next rx_en and check its spacing, tx_en and resulting sub_phase
   task automatic rx_step(input string tag, input int exp_gap, input logic exp_tx, input int exp_sp);
      int gap;
      gap = 0;
      do begin
         tick();
         gap++;
      end while (!rx_en && gap < 100);
      if (!rx_en) check({tag, "_timeout"}, 32'(rx_en), 32'd1);
      check({tag, "_gap"}, 32'(gap), 32'(exp_gap));
      check({tag, "_tx"}, 32'(tx_en), 32'(exp_tx));
      check({tag, "_sub_phase"}, 32'(sub_phase), 32'(exp_sp));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int frac_gaps[8];
      int pulses;
      frac_gaps = '{3, 3, 2, 3, 3, 2, 3, 3};
      reset    = 1'b1;
      locked   = 1'b1;
      inc_load = 1'b0;
      inc_data = '0;
      repeat (3) tick();
      check("rst_running", 32'(running), 32'd0);
      check("rst_rx", 32'(rx_en), 32'd0);
      check("rst_tx", 32'(tx_en), 32'd0);
      check("rst_busy", 32'(inc_busy), 32'd0);
      check("rst_sub_phase", 32'(sub_phase), 32'd0);

      // startup: inc=64 gives rx every 4 cycles, tx on every 4th rx
      reset = 1'b0;
      qualify("start");
      for (int k = 1; k <= 8; k++) rx_step("start", 4, (k % 4) == 0, k % 4);

      // fractional: load 96 while stopped, applied one edge after capture
      locked = 1'b0;
      tick();
      check("frac_stop_running", 32'(running), 32'd0);
      inc_load = 1'b1;
      inc_data = 8'd96;
      tick();
      check("frac_busy_set", 32'(inc_busy), 32'd1);
      inc_load = 1'b0;
      tick();
      check("frac_busy_clr", 32'(inc_busy), 32'd0);
      locked = 1'b1;
      qualify("frac");
      for (int k = 0; k < 8; k++) rx_step("frac", frac_gaps[k], ((k + 1) % 4) == 0, (k + 1) % 4);

      // mid-bit load of 128 at sub_phase 1; second load of 32 while busy must be dropped
      rx_step("midbit_pre", 2, 1'b0, 1);
      inc_load = 1'b1;
      inc_data = 8'd128;
      tick();
      check("midbit_busy_set", 32'(inc_busy), 32'd1);
      inc_data = 8'd32;
      tick();
      check("midbit_busy_hold", 32'(inc_busy), 32'd1);
      inc_load = 1'b0;
      rx_step("midbit_a", 1, 1'b0, 2);
      check("midbit_busy_a", 32'(inc_busy), 32'd1);
      rx_step("midbit_b", 3, 1'b0, 3);
      check("midbit_busy_b", 32'(inc_busy), 32'd1);
      rx_step("midbit_apply", 2, 1'b1, 0);
      check("midbit_busy_clr", 32'(inc_busy), 32'd0);
      rx_step("midbit_new", 2, 1'b0, 1);
      rx_step("midbit_new", 2, 1'b0, 2);

      // lock drop with acc=128, sub_phase=2
      tick();
      check("drop_pre_rx", 32'(rx_en), 32'd0);
      locked = 1'b0;
      tick();
      check("drop_running", 32'(running), 32'd0);
      check("drop_rx", 32'(rx_en), 32'd0);
      check("drop_tx", 32'(tx_en), 32'd0);
      check("drop_sub_phase", 32'(sub_phase), 32'd0);
      locked = 1'b1;
      qualify("relock");
      rx_step("relock", 2, 1'b0, 1);

      // zero increment: no pulses, then a load applies on the next edge
      locked = 1'b0;
      tick();
      inc_load = 1'b1;
      inc_data = 8'd0;
      tick();
      inc_load = 1'b0;
      tick();
      check("zero_busy_clr", 32'(inc_busy), 32'd0);
      locked = 1'b1;
      qualify("zero");
      pulses = 0;
      for (int i = 0; i < 1000; i++) begin
         tick();
         if (rx_en || tx_en) pulses++;
      end
      check("zero_pulses", 32'(pulses), 32'd0);
      check("zero_running", 32'(running), 32'd1);
      inc_load = 1'b1;
      inc_data = 8'd64;
      tick();
      check("zero_load_busy", 32'(inc_busy), 32'd1);
      inc_load = 1'b0;
      tick();
      check("zero_apply_busy", 32'(inc_busy), 32'd0);
      rx_step("zero_resume", 4, 1'b0, 1);

      // asynchronous reset mid-operation, then DEFAULT_INC is back in force
      inc_load = 1'b1;
      inc_data = 8'd10;
      tick();
      check("areset_pre_busy", 32'(inc_busy), 32'd1);
      inc_load = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("areset_running", 32'(running), 32'd0);
      check("areset_busy", 32'(inc_busy), 32'd0);
      check("areset_rx", 32'(rx_en), 32'd0);
      check("areset_tx", 32'(tx_en), 32'd0);
      check("areset_sub_phase", 32'(sub_phase), 32'd0);
      tick();
      reset = 1'b0;
      qualify("post_reset");
      rx_step("post_reset", 4, 1'b0, 1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
